// File: rtl/icini_mul_sequencer_if.sv
// Operand/result handshake bundle between the cipher datapath (master) and the ICINI sequencer (slave).
interface icini_mul_sequencer_if #(
  parameter int W = 3
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a0;
  logic [W-1:0] in_a1;
  logic [W-1:0] in_b0;
  logic [W-1:0] in_b1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_c0;
  logic [W-1:0] out_c1;

  modport master (
    output in_valid, in_a0, in_a1, in_b0, in_b1, out_ready,
    input  in_ready, out_valid, out_c0, out_c1
  );

  modport slave (
    input  in_valid, in_a0, in_a1, in_b0, in_b1, out_ready,
    output in_ready, out_valid, out_c0, out_c1
  );
endinterface

// File: rtl/icini_mul_sequencer.sv
// Sequences one 2-share masked ICINI multiplication: b shares + refresh bit, then a shares + mult bit,
// then captures the product shares. Latency accept->out_valid is 4 cycles; out_valid holds under backpressure.
module icini_mul_sequencer #(
  parameter int          W         = 3,
  parameter logic [15:0] SEED_INIT = 16'hACE1,
  parameter bit          PRECHARGE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  icini_mul_sequencer_if.slave   bus,
  input  logic                   seed_we,
  input  logic [15:0]            seed,
  output logic                   busy,
  output logic [W-1:0]           mul_a0,
  output logic [W-1:0]           mul_a1,
  output logic [W-1:0]           mul_b0,
  output logic [W-1:0]           mul_b1,
  output logic                   mul_rref,
  output logic                   mul_rmul,
  input  logic [W-1:0]           mul_c0,
  input  logic [W-1:0]           mul_c1
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_B,
    S_MULT,
    S_CAPTURE,
    S_OUT,
    S_CLEAR
  } state_t;

  state_t       state_q, state_d;
  logic [15:0]  lfsr_q, lfsr_d;
  logic [W-1:0] a0_q, a0_d, a1_q, a1_d;
  logic [W-1:0] b0_q, b0_d, b1_q, b1_d;
  logic [W-1:0] c0_q, c0_d, c1_q, c1_d;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form; bit 0 is the emitted random bit
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_INIT;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    a0_d          = a0_q;
    a1_d          = a1_q;
    b0_d          = b0_q;
    b1_d          = b1_q;
    c0_d          = c0_q;
    c1_d          = c1_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    mul_a0        = '0;
    mul_a1        = '0;
    mul_b0        = '0;
    mul_b1        = '0;
    mul_rref      = 1'b0;
    mul_rmul      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (seed_we && (seed != 16'h0000)) begin
          lfsr_d = seed;
        end
        if (bus.in_valid) begin
          a0_d    = bus.in_a0;
          a1_d    = bus.in_a1;
          b0_d    = bus.in_b0;
          b1_d    = bus.in_b1;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        mul_b0   = b0_q;
        mul_b1   = b1_q;
        mul_rref = lfsr_q[0];
        lfsr_d   = lfsr_step(lfsr_q);
        state_d  = S_MULT;
      end
      S_MULT: begin
        mul_a0   = a0_q;
        mul_a1   = a1_q;
        mul_rmul = lfsr_q[0];
        lfsr_d   = lfsr_step(lfsr_q);
        // operand shares must not linger once the multiplier has consumed them
        a0_d     = '0;
        a1_d     = '0;
        b0_d     = '0;
        b1_d     = '0;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        c0_d    = mul_c0;
        c1_d    = mul_c1;
        state_d = S_OUT;
      end
      S_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          c0_d    = '0;
          c1_d    = '0;
          state_d = PRECHARGE ? S_CLEAR : S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign bus.out_c0 = c0_q;
  assign bus.out_c1 = c1_q;

endmodule

// File: tb/tb_icini_mul_sequencer.sv
// Directed bench for icini_mul_sequencer with a behavioural two-share multiplier attached to the mul_* ports.
module tb_icini_mul_sequencer;
  localparam int W = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  icini_mul_sequencer_if #(.W(W)) bus ();

  logic         seed_we;
  logic [15:0]  seed;
  logic         busy;
  logic [W-1:0] mul_a0, mul_a1, mul_b0, mul_b1, mul_c0, mul_c1;
  logic         mul_rref, mul_rmul;

  icini_mul_sequencer #(.W(W), .SEED_INIT(16'hACE1), .PRECHARGE(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .seed_we  (seed_we),
    .seed     (seed),
    .busy     (busy),
    .mul_a0   (mul_a0),
    .mul_a1   (mul_a1),
    .mul_b0   (mul_b0),
    .mul_b1   (mul_b1),
    .mul_rref (mul_rref),
    .mul_rmul (mul_rmul),
    .mul_c0   (mul_c0),
    .mul_c1   (mul_c1)
  );

  // Multiplier stand-in: accumulates whatever shares appear during the op, masks the product with the rand bits.
  logic [W-1:0] ma0, ma1, mb0, mb1;
  logic         mr;
  always @(posedge clk) begin
    if (!busy) begin
      ma0 <= '0; ma1 <= '0; mb0 <= '0; mb1 <= '0; mr <= 1'b0;
    end else begin
      ma0 <= ma0 | mul_a0;
      ma1 <= ma1 | mul_a1;
      mb0 <= mb0 | mul_b0;
      mb1 <= mb1 | mul_b1;
      mr  <= mr ^ mul_rref ^ mul_rmul;
    end
  end
  assign mul_c1 = {W{mr}};
  assign mul_c0 = ((ma0 ^ ma1) & (mb0 ^ mb1)) ^ {W{mr}};

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_acc = 0;
  bit          iv_on = 1'b0;
  logic [15:0] lfsr_m;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    r[15] = s[0] ^ s[2] ^ s[3] ^ s[5];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mul_zero(input string tag);
    chk(tag, 32'({mul_a0, mul_a1, mul_b0, mul_b1, mul_rref, mul_rmul}), 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input logic [W-1:0] b0, input logic [W-1:0] b1,
                        input int stall, input logic [15:0] new_seed, input bit mid_seed);
    logic [W-1:0] prod, exp_c0, exp_c1;
    logic         r_ref, r_mul;
    prod = (a0 ^ a1) & (b0 ^ b1);

    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk_mul_zero("idle_mul_zero");
    bus.in_valid = 1'b1;
    bus.in_a0 = a0; bus.in_a1 = a1; bus.in_b0 = b0; bus.in_b1 = b1;
    if (new_seed != 16'h0000) begin
      seed_we = 1'b1;
      seed    = new_seed;
      lfsr_m  = new_seed;
    end
    tick();
    if (iv_on) chk("issue_interval", 32'(cyc - last_acc), 32'd6);
    last_acc = cyc;
    bus.in_valid = 1'b0;
    seed_we = 1'b0;
    bus.in_a0 = W'($urandom); bus.in_a1 = W'($urandom);
    bus.in_b0 = W'($urandom); bus.in_b1 = W'($urandom);

    // LOAD_B
    chk("loadb_in_ready", 32'(bus.in_ready), 32'd0);
    chk("loadb_busy", 32'(busy), 32'd1);
    chk("loadb_mul_b", 32'({mul_b0, mul_b1}), 32'({b0, b1}));
    chk("loadb_a_rmul_zero", 32'({mul_a0, mul_a1, mul_rmul}), 32'd0);
    chk("loadb_rref", 32'(mul_rref), 32'(lfsr_m[0]));
    r_ref  = lfsr_m[0];
    lfsr_m = model_step(lfsr_m);
    if (mid_seed) begin
      seed_we = 1'b1;
      seed    = 16'h1234;
    end
    tick();

    // MULT
    chk("mult_mul_a", 32'({mul_a0, mul_a1}), 32'({a0, a1}));
    chk("mult_b_rref_zero", 32'({mul_b0, mul_b1, mul_rref}), 32'd0);
    chk("mult_rmul", 32'(mul_rmul), 32'(lfsr_m[0]));
    r_mul  = lfsr_m[0];
    lfsr_m = model_step(lfsr_m);
    seed_we = 1'b0;
    tick();

    // CAPTURE
    chk_mul_zero("capture_mul_zero");
    chk("capture_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = (stall == 0);
    tick();

    // OUT
    exp_c1 = {W{r_ref ^ r_mul}};
    exp_c0 = prod ^ exp_c1;
    chk("out_valid", 32'(bus.out_valid), 32'd1);
    chk("out_c0", 32'(bus.out_c0), 32'(exp_c0));
    chk("out_c1", 32'(bus.out_c1), 32'(exp_c1));
    chk("out_c_xor", 32'(bus.out_c0 ^ bus.out_c1), 32'(prod));
    chk_mul_zero("out_mul_zero");
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      tick();
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_out_c", 32'({bus.out_c0, bus.out_c1}), 32'({exp_c0, exp_c1}));
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk_mul_zero("stall_mul_zero");
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    // CLEAR
    chk("clear_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clear_out_c", 32'({bus.out_c0, bus.out_c1}), 32'd0);
    chk("clear_in_ready", 32'(bus.in_ready), 32'd0);
    chk("clear_busy", 32'(busy), 32'd1);
    chk_mul_zero("clear_mul_zero");
    tick();
    chk("back_idle_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a0 = '0; bus.in_a1 = '0; bus.in_b0 = '0; bus.in_b1 = '0;
    bus.out_ready = 1'b1;
    seed_we = 1'b0;
    seed = 16'h0000;

    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_c", 32'({bus.out_c0, bus.out_c1}), 32'd0);
    chk_mul_zero("rst_mul_zero");
    reset = 1'b1;
    lfsr_m = 16'hACE1;
    tick();

    // Hand vector: a=5, b=3 -> product 1; ACE1 yields rref=1, rmul=0.
    run_op(3'b101, 3'b000, 3'b011, 3'b000, 0, 16'h0000, 1'b0);

    // Back-to-back random ops
    for (int n = 0; n < 200; n++) begin
      run_op(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0, 16'h0000, 1'b0);
      iv_on = 1'b1;
    end
    iv_on = 1'b0;

    // Backpressure for 7 cycles, then an op confirming the LFSR did not advance
    run_op(3'b110, 3'b011, 3'b111, 3'b010, 7, 16'h0000, 1'b0);
    run_op(3'b111, 3'b000, 3'b111, 3'b000, 0, 16'h0000, 1'b0);

    // Seed load in IDLE: 0001 gives rref=1, rmul=0
    seed_we = 1'b1; seed = 16'h0001;
    tick();
    seed_we = 1'b0;
    lfsr_m = 16'h0001;
    run_op(3'b011, 3'b001, 3'b110, 3'b100, 0, 16'h0000, 1'b0);

    // Zero seed ignored
    seed_we = 1'b1; seed = 16'h0000;
    tick();
    seed_we = 1'b0;
    run_op(3'b100, 3'b010, 3'b101, 3'b011, 0, 16'h0000, 1'b0);

    // Seed write during MULT ignored, then seed coinciding with accept
    run_op(3'b001, 3'b110, 3'b011, 3'b101, 0, 16'h0000, 1'b1);
    run_op(3'b010, 3'b111, 3'b001, 3'b100, 0, 16'h0000, 1'b0);
    run_op(3'b111, 3'b001, 3'b110, 3'b000, 0, 16'hBEEF, 1'b0);
    run_op(3'b101, 3'b101, 3'b011, 3'b110, 0, 16'h0000, 1'b0);

    // Reset during MULT
    bus.in_valid = 1'b1;
    bus.in_a0 = 3'b111; bus.in_a1 = 3'b000; bus.in_b0 = 3'b111; bus.in_b1 = 3'b000;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("pre_reset_in_mult", 32'({mul_a0, mul_a1}), 32'({3'b111, 3'b000}));
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_c", 32'({bus.out_c0, bus.out_c1}), 32'd0);
    chk_mul_zero("midrst_mul_zero");
    tick();
    chk("midrst_hold_out_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b1;
    lfsr_m = 16'hACE1;
    tick();
    chk("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    run_op(3'b101, 3'b000, 3'b011, 3'b000, 0, 16'h0000, 1'b0);
    run_op(3'b010, 3'b011, 3'b110, 3'b111, 2, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
